text_buffer_writer: RTL and testbench

Character-stream front end for the VGA text path. Accepts one ASCII byte per handshake from the CPU side, interprets printable characters and a small set of control codes, and maintains the 256-cell screen buffer (8 rows × 32 columns) presented as `char_data` to the VGA top, which renders it. Owns the cursor, line wrap, scrolling and screen clear; all buffer storage lives here.

---
 rtl/text_pkg.sv | 21 ++
 rtl/text_cursor.sv | 57 +++++
 rtl/text_buffer_writer.sv | 112 +++++++++++
 tb/tb_text_buffer_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM state type
// for the text buffer writer and its cursor logic.
package text_pkg;

    localparam int COLS  = 32;
    localparam int ROWS  = 8;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] CHAR_BLANK = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        CLEAR
    } tb_state_t;

endpackage

// File: rtl/text_cursor.sv
// Next-cursor, cell-write and scroll/clear request decode
// for one incoming byte at the current cursor.
module text_cursor
    import text_pkg::*;
(
    input  logic [7:0] i_cursor,
    input  logic [7:0] i_data,
    output logic [7:0] o_next,
    output logic       o_we,
    output logic [7:0] o_idx,
    output logic [7:0] o_char,
    output logic       o_scroll,
    output logic       o_clear
);

    localparam logic [7:0] LAST_CELL = 8'(CELLS - 1);
    localparam logic [7:0] LAST_ROW  = 8'(CELLS - COLS);
    localparam logic [7:0] COL_MASK  = 8'(COLS - 1);

    logic [7:0] w_start;
    logic       w_print;

    assign w_start = i_cursor & ~COL_MASK;
    assign w_print = (i_data >= 8'h20) && (i_data <= 8'h7E);

    always_comb begin
        o_next   = i_cursor;
        o_we     = 1'b0;
        o_idx    = i_cursor;
        o_char   = i_data;
        o_scroll = 1'b0;
        o_clear  = 1'b0;
        unique case (1'b1)
            w_print: begin
                o_we = 1'b1;
                if (i_cursor == LAST_CELL) o_scroll = 1'b1;
                else o_next = i_cursor + 8'd1;
            end
            (i_data == CHAR_LF): begin
                if (i_cursor >= LAST_ROW) o_scroll = 1'b1;
                else o_next = w_start + 8'(COLS);
            end
            (i_data == CHAR_CR): o_next = w_start;
            (i_data == CHAR_BS): begin
                if (i_cursor != 8'd0) begin
                    o_next = i_cursor - 8'd1;
                    o_idx  = i_cursor - 8'd1;
                    o_char = CHAR_BLANK;
                    o_we   = 1'b1;
                end
            end
            (i_data == CHAR_FF): o_clear = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/text_buffer_writer.sv
// Character-stream front end: owns the 256-cell screen buffer,
// cursor, row-at-a-time scroll and clear for the VGA text path.
module text_buffer_writer #(
    parameter int COLS = 32,
    parameter int ROWS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    input  logic [7:0]                wr_data,
    output logic                      wr_ready,
    output logic [COLS*ROWS-1:0][7:0] char_data,
    output logic [7:0]                cursor,
    output logic                      busy
);
    import text_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_IDX = RW'(ROWS - 1);
    localparam logic [7:0] SCROLL_CUR = 8'(COLS * (ROWS - 1));

    tb_state_t r_state;
    tb_state_t w_state_nx;

    logic [RW-1:0]              r_row_idx;
    logic [7:0]                 r_cursor;
    logic [COLS*ROWS-1:0][7:0]  r_cells;

    logic       w_accept;
    logic       w_last;
    logic [7:0] w_next;
    logic       w_we;
    logic [7:0] w_idx;
    logic [7:0] w_char;
    logic       w_scroll;
    logic       w_clear;
    logic [7:0] w_base;
    logic [7:0] w_src;

    text_cursor u_cursor (
        .i_cursor (r_cursor),
        .i_data   (wr_data),
        .o_next   (w_next),
        .o_we     (w_we),
        .o_idx    (w_idx),
        .o_char   (w_char),
        .o_scroll (w_scroll),
        .o_clear  (w_clear)
    );

    assign wr_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign cursor    = r_cursor;
    assign char_data = r_cells;
    assign w_accept  = wr_valid && wr_ready;
    assign w_last    = (r_row_idx == LAST_IDX);
    assign w_base    = 8'(r_row_idx) * 8'(COLS);
    assign w_src     = w_base + 8'(COLS);

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_scroll) w_state_nx = SCROLL;
                else if (w_accept && w_clear) w_state_nx = CLEAR;
            end
            SCROLL, CLEAR: if (w_last) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_row_idx <= '0;
            r_cursor  <= '0;
            r_cells   <= {(COLS*ROWS){CHAR_BLANK}};
        end else begin
            r_state <= w_state_nx;
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_we) r_cells[w_idx] <= w_char;
                    if (w_accept && !w_scroll && !w_clear) r_cursor <= w_next;
                end
                SCROLL: begin
                    // Rows shift up one per cycle; the final pass blanks the bottom row.
                    for (int c = 0; c < COLS; c++) begin
                        if (w_last) r_cells[w_base + 8'(c)] <= CHAR_BLANK;
                        else r_cells[w_base + 8'(c)] <= r_cells[w_src + 8'(c)];
                    end
                    r_row_idx <= r_row_idx + RW'(1);
                    if (w_last) begin
                        r_row_idx <= '0;
                        r_cursor  <= SCROLL_CUR;
                    end
                end
                CLEAR: begin
                    for (int c = 0; c < COLS; c++) begin
                        r_cells[w_base + 8'(c)] <= CHAR_BLANK;
                    end
                    r_row_idx <= r_row_idx + RW'(1);
                    if (w_last) begin
                        r_row_idx <= '0;
                        r_cursor  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench: directed vector table, multi-cycle corner
// sequences and random bytes against a screen-level reference model.
module tb_text_buffer_writer;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_valid = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              wr_ready;
    logic [255:0][7:0] char_data;
    logic [7:0]        cursor;
    logic              busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_cells [256];
    int         m_cur;

    typedef struct {
        logic [7:0] b;
        int         cur;
        int         idx;
        logic [7:0] val;
    } vec_t;

    vec_t vecs [$];

    text_buffer_writer #(.COLS(32), .ROWS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .char_data (char_data),
        .cursor    (cursor),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < 256; i++) m_cells[i] = 8'h20;
        m_cur = 0;
    endfunction

    function automatic void m_scroll();
        for (int i = 0; i < 224; i++) m_cells[i] = m_cells[i + 32];
        for (int i = 224; i < 256; i++) m_cells[i] = 8'h20;
    endfunction

    // Returns the number of cycles the block should stay busy.
    function automatic int m_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_cells[m_cur] = b;
            if (m_cur == 255) begin
                m_scroll();
                m_cur = 224;
                return 8;
            end
            m_cur = m_cur + 1;
        end else if (b == 8'h0A) begin
            if (m_cur / 32 == 7) begin
                m_scroll();
                m_cur = 224;
                return 8;
            end
            m_cur = (m_cur / 32 + 1) * 32;
        end else if (b == 8'h0D) begin
            m_cur = (m_cur / 32) * 32;
        end else if (b == 8'h08) begin
            if (m_cur > 0) begin
                m_cur = m_cur - 1;
                m_cells[m_cur] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            m_reset();
            return 8;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 256; i++) begin
            if (char_data[i] !== m_cells[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_cells: %0d cells differ, cell %0d got %0h expected %0h",
                     name, bad, first, char_data[first], m_cells[first]);
        end
        check({name, "_cursor"}, cursor, m_cur);
        check({name, "_ready"}, {wr_ready, busy}, 2'b10);
    endtask

    task automatic send(input logic [7:0] b, input bit hold);
        int n = 0;
        wr_data  = b;
        wr_valid = 1'b1;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: wr_ready got 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int e;
        logic [7:0] b;
        int r;

        m_reset();
        repeat (2) @(negedge clk);
        check_model("reset_held");
        reset = 1'b1;
        @(negedge clk);
        check_model("reset_release");

        vecs.push_back('{8'h48, 1, 0, 8'h48});
        vecs.push_back('{8'h69, 2, 1, 8'h69});
        vecs.push_back('{8'h08, 1, 1, 8'h20});
        vecs.push_back('{8'h08, 0, 0, 8'h20});
        vecs.push_back('{8'h08, 0, 0, 8'h20});
        for (int k = 0; k < 5; k++)
            vecs.push_back('{8'(8'h61 + k), k + 1, k, 8'(8'h61 + k)});
        vecs.push_back('{8'h08, 4, 4, 8'h20});
        vecs.push_back('{8'h0D, 0, 3, 8'h64});
        vecs.push_back('{8'h0A, 32, 0, 8'h61});
        for (int k = 0; k < 8; k++)
            vecs.push_back('{8'h78, 33 + k, 32 + k, 8'h78});
        vecs.push_back('{8'h0A, 64, 39, 8'h78});
        vecs.push_back('{8'h41, 65, 64, 8'h41});
        vecs.push_back('{8'h42, 66, 65, 8'h42});
        vecs.push_back('{8'h0D, 64, 65, 8'h42});
        vecs.push_back('{8'h07, 64, 66, 8'h20});

        for (int i = 0; i < vecs.size(); i++) begin
            e = m_apply(vecs[i].b);
            send(vecs[i].b, 1'b0);
            check($sformatf("vec%0d_cursor", i), cursor, vecs[i].cur);
            check($sformatf("vec%0d_cell", i), char_data[vecs[i].idx], vecs[i].val);
            wait_idle(n);
            check($sformatf("vec%0d_busy", i), n, e);
            check_model($sformatf("vec%0d", i));
        end

        // Full-screen fill with wr_valid held high through the scroll.
        e = m_apply(8'h0C);
        send(8'h0C, 1'b0);
        wait_idle(n);
        check("ff_busy", n, 8);
        check_model("ff_pre_fill");
        for (int i = 0; i < 256; i++) begin
            b = 8'(8'h41 + i / 32);
            e = m_apply(b);
            send(b, 1'b1);
        end
        wr_data = 8'h5A;
        n = 0;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fill_busy", n, 8);
        check("fill_row0", char_data[0], 8'h42);
        check("fill_row6", char_data[223], 8'h48);
        check("fill_row7", char_data[224], 8'h20);
        check_model("fill_scrolled");
        e = m_apply(8'h5A);
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        check("fill_257th", char_data[224], 8'h5A);
        check_model("fill_257th");

        e = m_apply(8'h0C);
        send(8'h0C, 1'b0);
        wait_idle(n);
        check("ff_full_busy", n, 8);
        check("ff_full_cursor", cursor, 0);
        check_model("ff_full");

        // Reset part way through a scroll.
        e = m_apply(8'h5A);
        send(8'h5A, 1'b0);
        for (int k = 0; k < 7; k++) begin
            e = m_apply(8'h0A);
            send(8'h0A, 1'b0);
        end
        check("pre_scroll_cursor", cursor, 224);
        send(8'h0A, 1'b0);
        check("scroll_started", wr_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        m_reset();
        check_model("reset_in_scroll");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_after_ready", wr_ready, 1'b1);
        e = m_apply(8'h51);
        send(8'h51, 1'b0);
        check_model("after_reset_write");

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) b = 8'($urandom_range(32, 126));
            else if (r < 80) b = 8'h0A;
            else if (r < 85) b = 8'h0D;
            else if (r < 93) b = 8'h08;
            else if (r < 95) b = 8'h0C;
            else b = 8'($urandom_range(0, 255));
            e = m_apply(b);
            send(b, 1'b0);
            wait_idle(n);
            check($sformatf("rnd%0d_busy", i), n, e);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
